// File: rtl/acoustic_pkg.sv
// Shared constants and types for the microphone decimation chain.
package acoustic_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int ACC_W     = 48;
    localparam int HB_SHIFT  = 17;
    localparam int HB_WARMUP = 10;

    typedef enum logic {
        ST_WARMUP,
        ST_RUN
    } warm_state_e;

endpackage

// File: rtl/hb_decim_requant_if.sv
// Sample-in / sample-out handshake bundle for the half-band requantiser.
interface hb_decim_requant_if import acoustic_pkg::*; #(
    parameter int IN_W  = ACC_W,
    parameter int OUT_W = SAMPLE_W
);
    logic             in_valid;
    logic [IN_W-1:0]  y_in;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output in_valid, y_in, out_ready, input out_data, out_valid);
    modport slave  (input in_valid, y_in, out_ready, output out_data, out_valid);
endinterface

// File: rtl/sample_fifo.sv
// Sample FIFO with a registered head word; push and pop may coincide when full.
module sample_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clkdiv,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  head_q, head_d;
    logic          wr_en, rd_en;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = head_q;
    assign level = count_q;

    always_comb begin
        rd_en = pop && !empty;
        wr_en = push && (!full || rd_en);
        mem_d = mem_q;
        if (wr_en) mem_d[wr_ptr_q] = din;
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        // Head looks through the write so a push into an empty FIFO is visible next cycle.
        head_d   = mem_d[rd_ptr_d];
    end

    always_ff @(posedge clkdiv or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end
endmodule

// File: rtl/hb_decim_requant.sv
// Half-band output stage: warm-up discard, decimate by 2, round-half-up, saturate, FIFO.
module hb_decim_requant import acoustic_pkg::*; #(
    parameter int IN_W   = ACC_W,
    parameter int OUT_W  = SAMPLE_W,
    parameter int SHIFT  = HB_SHIFT,
    parameter int PHASE  = 0,
    parameter int WARMUP = HB_WARMUP,
    parameter int DEPTH  = 8
) (
    input  logic                   clkdiv,
    input  logic                   rst,
    hb_decim_requant_if.slave      bus,
    input  logic                   clear_stat,
    output logic                   overflow,
    output logic [15:0]            drop_count,
    output logic [15:0]            sat_count,
    output logic [$clog2(DEPTH):0] level
);
    localparam int WCW = $clog2(WARMUP + 2);
    localparam logic [IN_W:0] ROUND_K = (IN_W+1)'(1) << (SHIFT - 1);
    localparam warm_state_e RST_STATE = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

    warm_state_e        state_q, state_d;
    logic [WCW-1:0]     warm_cnt_q, warm_cnt_d;
    logic               phase_q, phase_d;
    logic               s1_valid_q, s1_valid_d;
    logic signed [IN_W:0] s1_val_q, s1_val_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        drop_count_q, drop_count_d;
    logic [15:0]        sat_count_q, sat_count_d;

    logic               keep, in_range, sat_evt, pop, drop;
    logic [IN_W:0]      y_sum;
    logic signed [IN_W:0] y_rnd;
    logic [IN_W:OUT_W-1] hi_bits;
    logic [OUT_W-1:0]   sat_val;
    logic               fifo_full, fifo_empty;
    logic [OUT_W-1:0]   fifo_head;

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        phase_d    = phase_q;
        keep       = 1'b0;
        if (bus.in_valid) begin
            case (state_q)
                ST_WARMUP: begin
                    warm_cnt_d = warm_cnt_q + WCW'(1);
                    if (warm_cnt_q == WCW'(WARMUP - 1)) state_d = ST_RUN;
                end
                ST_RUN: begin
                    keep    = (phase_q == 1'(PHASE));
                    phase_d = ~phase_q;
                end
                default: state_d = RST_STATE;
            endcase
        end

        y_sum      = {bus.y_in[IN_W-1], bus.y_in} + ROUND_K;
        y_rnd      = $signed(y_sum) >>> SHIFT;
        s1_valid_d = keep;
        s1_val_d   = keep ? y_rnd : s1_val_q;

        // The shifted value fits OUT_W bits only if all bits above the output sign agree.
        hi_bits  = s1_val_q[IN_W:OUT_W-1];
        in_range = (&hi_bits) || !(|hi_bits);
        if (in_range)         sat_val = s1_val_q[OUT_W-1:0];
        else if (s1_val_q[IN_W]) sat_val = {1'b1, {(OUT_W-1){1'b0}}};
        else                  sat_val = {1'b0, {(OUT_W-1){1'b1}}};
        sat_evt = s1_valid_q && !in_range;

        pop  = bus.out_valid && bus.out_ready;
        drop = s1_valid_q && fifo_full && !pop;

        overflow_d   = drop || (overflow_q && !clear_stat);
        drop_count_d = drop_count_q;
        if (clear_stat)                         drop_count_d = 16'(drop);
        else if (drop && drop_count_q != '1)    drop_count_d = drop_count_q + 16'd1;
        sat_count_d = sat_count_q;
        if (clear_stat)                         sat_count_d = 16'(sat_evt);
        else if (sat_evt && sat_count_q != '1)  sat_count_d = sat_count_q + 16'd1;
    end

    always_ff @(posedge clkdiv or posedge rst) begin
        if (rst) begin
            state_q      <= RST_STATE;
            warm_cnt_q   <= '0;
            phase_q      <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_val_q     <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            sat_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            warm_cnt_q   <= warm_cnt_d;
            phase_q      <= phase_d;
            s1_valid_q   <= s1_valid_d;
            s1_val_q     <= s1_val_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            sat_count_q  <= sat_count_d;
        end
    end

    sample_fifo #(.W(OUT_W), .DEPTH(DEPTH)) u_fifo (
        .clkdiv (clkdiv),
        .rst    (rst),
        .push   (s1_valid_q),
        .din    (sat_val),
        .pop    (pop),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level)
    );

    assign bus.out_data  = fifo_head;
    assign bus.out_valid = !fifo_empty;
    assign overflow      = overflow_q;
    assign drop_count    = drop_count_q;
    assign sat_count     = sat_count_q;
endmodule
